// File: rtl/player_action_sched.sv
// -----------------------------------------------------------------------------
// player_action_sched
//
// Per-player action scheduler. Arbitrates the fighter's single action resource
// between walk, jump, two attacks and the resolver's hit event, and owns the
// attack, jump and hitstun frame counters. Every state change is qualified by
// the SCEN game-tick enable; all outputs are registered (one tick of latency).
//
// Optional feature macro: ATTACK_BUFFER_EN
//   defined   : attack presses made while busy are held in a 1-deep buffer and
//               launched on the tick the current action finishes.
//   undefined : presses made while busy are discarded.
//
// Ports:
//   clk, reset (async, active-low)
//   SCEN                         game-tick enable
//   btn_left/right/jump          level requests
//   btn_atk1/atk2                attack buttons (rising edge = press)
//   hit_in                       resolver hit event
//   hitstun_active, attack_active, move_active, jump_active, busy
//   attack_type[1:0], attack_frame[5:0], jump_frame[5:0], move_dir
// -----------------------------------------------------------------------------
module player_action_sched #(
    parameter int ATK1_FRAMES    = 12,
    parameter int ATK2_FRAMES    = 20,
    parameter int JUMP_FRAMES    = 32,
    parameter int HITSTUN_FRAMES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SCEN,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic       btn_atk1,
    input  logic       btn_atk2,
    input  logic       hit_in,
    output logic       hitstun_active,
    output logic       attack_active,
    output logic [1:0] attack_type,
    output logic [5:0] attack_frame,
    output logic       move_active,
    output logic       move_dir,
    output logic       jump_active,
    output logic [5:0] jump_frame,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WALK    = 3'd1,
        ST_JUMP    = 3'd2,
        ST_ATTACK  = 3'd3,
        ST_HITSTUN = 3'd4
    } state_t;

    // Index of the final tick of each action.
    localparam logic [5:0] ATK1_LAST    = 6'(ATK1_FRAMES - 1);
    localparam logic [5:0] ATK2_LAST    = 6'(ATK2_FRAMES - 1);
    localparam logic [5:0] JUMP_LAST    = 6'(JUMP_FRAMES - 1);
    localparam logic [5:0] HITSTUN_LAST = 6'(HITSTUN_FRAMES - 1);

    // Counters saturate at 63 rather than wrap.
    function automatic logic [5:0] sat_inc(input logic [5:0] v);
        if (v == 6'd63) begin
            sat_inc = v;
        end else begin
            sat_inc = v + 6'd1;
        end
    endfunction

    state_t     state_r;
    state_t     state_n;
    logic [5:0] hs_cnt_r;
    logic [5:0] hs_cnt_n;
    logic [1:0] type_n;
    logic [5:0] atk_frame_n;
    logic [5:0] jump_frame_n;
    logic       move_dir_n;
    logic       prev_atk1_r;
    logic       prev_atk2_r;
    logic       atk1_press_s;
    logic       atk2_press_s;
    logic [5:0] atk_last_s;
    logic       finish_s;
`ifdef ATTACK_BUFFER_EN
    logic       buf_valid_r;
    logic [1:0] buf_type_r;
    logic       buf_valid_n;
    logic [1:0] buf_type_n;
    logic       cap_valid_s;
    logic [1:0] cap_type_s;
    logic       busy_state_s;
`endif

    assign atk1_press_s = btn_atk1 & ~prev_atk1_r;
    assign atk2_press_s = btn_atk2 & ~prev_atk2_r;
    assign atk_last_s   = (attack_type == 2'd2) ? ATK2_LAST : ATK1_LAST;

    // Current action is on its last tick; the next tick returns to idle.
    assign finish_s = ((state_r == ST_ATTACK)  && (attack_frame >= atk_last_s)) ||
                      ((state_r == ST_JUMP)    && (jump_frame   >= JUMP_LAST))  ||
                      ((state_r == ST_HITSTUN) && (hs_cnt_r     >= HITSTUN_LAST));

    // Next-state and next-counter decision for one game tick.
    always_comb begin
        state_n      = ST_IDLE;
        type_n       = 2'd0;
        atk_frame_n  = 6'd0;
        jump_frame_n = 6'd0;
        hs_cnt_n     = 6'd0;
        move_dir_n   = move_dir;
`ifdef ATTACK_BUFFER_EN
        buf_valid_n  = buf_valid_r;
        buf_type_n   = buf_type_r;
        cap_valid_s  = buf_valid_r;
        cap_type_s   = buf_type_r;
        busy_state_s = (state_r == ST_ATTACK) || (state_r == ST_JUMP) ||
                       (state_r == ST_HITSTUN);
`endif
        if (hit_in) begin
            // A hit pre-empts everything and restarts hitstun from zero.
            state_n = ST_HITSTUN;
`ifdef ATTACK_BUFFER_EN
            buf_valid_n = 1'b0;
            buf_type_n  = 2'd0;
`endif
        end else begin
            case (state_r)
                ST_IDLE, ST_WALK: begin
                    if (atk1_press_s) begin
                        state_n = ST_ATTACK;
                        type_n  = 2'd1;
                    end else if (atk2_press_s) begin
                        state_n = ST_ATTACK;
                        type_n  = 2'd2;
                    end else if (btn_jump) begin
                        state_n = ST_JUMP;
                    end else if (btn_left ^ btn_right) begin
                        state_n    = ST_WALK;
                        move_dir_n = btn_right;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_ATTACK: begin
                    if (finish_s) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n     = ST_ATTACK;
                        type_n      = attack_type;
                        atk_frame_n = sat_inc(attack_frame);
                    end
                end
                ST_JUMP: begin
                    if (finish_s) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n      = ST_JUMP;
                        jump_frame_n = sat_inc(jump_frame);
                    end
                end
                ST_HITSTUN: begin
                    if (finish_s) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n  = ST_HITSTUN;
                        hs_cnt_n = sat_inc(hs_cnt_r);
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
`ifdef ATTACK_BUFFER_EN
            // Capture presses made while busy; atk1 wins a same-tick tie and a
            // newer press replaces an older one.
            if (busy_state_s && atk1_press_s) begin
                cap_valid_s = 1'b1;
                cap_type_s  = 2'd1;
            end else if (busy_state_s && atk2_press_s) begin
                cap_valid_s = 1'b1;
                cap_type_s  = 2'd2;
            end else begin
                cap_valid_s = buf_valid_r;
                cap_type_s  = buf_type_r;
            end
            // A buffered attack launches directly, skipping the idle tick.
            if (finish_s && cap_valid_s) begin
                state_n     = ST_ATTACK;
                type_n      = cap_type_s;
                atk_frame_n = 6'd0;
                buf_valid_n = 1'b0;
                buf_type_n  = 2'd0;
            end else begin
                buf_valid_n = cap_valid_s;
                buf_type_n  = cap_type_s;
            end
`endif
        end
    end

    // State, counters, press history and registered outputs; advance on SCEN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            hs_cnt_r       <= 6'd0;
            prev_atk1_r    <= 1'b0;
            prev_atk2_r    <= 1'b0;
            hitstun_active <= 1'b0;
            attack_active  <= 1'b0;
            attack_type    <= 2'd0;
            attack_frame   <= 6'd0;
            move_active    <= 1'b0;
            move_dir       <= 1'b1;
            jump_active    <= 1'b0;
            jump_frame     <= 6'd0;
            busy           <= 1'b0;
`ifdef ATTACK_BUFFER_EN
            buf_valid_r    <= 1'b0;
            buf_type_r     <= 2'd0;
`endif
        end else if (SCEN) begin
            state_r        <= state_n;
            hs_cnt_r       <= hs_cnt_n;
            prev_atk1_r    <= btn_atk1;
            prev_atk2_r    <= btn_atk2;
            hitstun_active <= (state_n == ST_HITSTUN);
            attack_active  <= (state_n == ST_ATTACK);
            attack_type    <= type_n;
            attack_frame   <= atk_frame_n;
            move_active    <= (state_n == ST_WALK);
            move_dir       <= move_dir_n;
            jump_active    <= (state_n == ST_JUMP);
            jump_frame     <= jump_frame_n;
            busy           <= (state_n == ST_ATTACK) || (state_n == ST_JUMP) ||
                              (state_n == ST_HITSTUN);
`ifdef ATTACK_BUFFER_EN
            buf_valid_r    <= buf_valid_n;
            buf_type_r     <= buf_type_n;
`endif
        end
    end

endmodule

// File: tb/tb_player_action_sched.sv
// -----------------------------------------------------------------------------
// tb_player_action_sched
//
// Randomised plus directed stimulus against a behavioural model of the action
// scheduler. The stimulus side pushes each tick's expected outputs into a
// queue; a monitor pops and compares after every rising clock edge.
// -----------------------------------------------------------------------------
module tb_player_action_sched;

    localparam int ATK1 = 12;
    localparam int ATK2 = 20;
    localparam int JMP  = 32;
    localparam int HS   = 16;

    localparam int M_IDLE = 0;
    localparam int M_WALK = 1;
    localparam int M_JUMP = 2;
    localparam int M_ATK  = 3;
    localparam int M_HIT  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       SCEN;
    logic       btn_left, btn_right, btn_jump, btn_atk1, btn_atk2, hit_in;
    logic       hitstun_active, attack_active, move_active, move_dir, jump_active, busy;
    logic [1:0] attack_type;
    logic [5:0] attack_frame, jump_frame;

    player_action_sched #(
        .ATK1_FRAMES(ATK1), .ATK2_FRAMES(ATK2),
        .JUMP_FRAMES(JMP),  .HITSTUN_FRAMES(HS)
    ) dut (
        .clk(clk), .reset(reset), .SCEN(SCEN),
        .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
        .btn_atk1(btn_atk1), .btn_atk2(btn_atk2), .hit_in(hit_in),
        .hitstun_active(hitstun_active), .attack_active(attack_active),
        .attack_type(attack_type), .attack_frame(attack_frame),
        .move_active(move_active), .move_dir(move_dir),
        .jump_active(jump_active), .jump_frame(jump_frame), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] v;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Behavioural model: current activity, elapsed ticks in it, attack kind.
    int m_mode, m_t, m_kind, m_bk;
    bit m_dir, m_p1, m_p2, m_bv;

    task automatic model_reset();
        m_mode = M_IDLE; m_t = 0; m_kind = 0; m_dir = 1'b1;
        m_p1 = 1'b0; m_p2 = 1'b0; m_bv = 1'b0; m_bk = 0;
    endtask

    function automatic int duration();
        if (m_mode == M_JUMP) return JMP;
        if (m_mode == M_HIT)  return HS;
        return (m_kind == 2) ? ATK2 : ATK1;
    endfunction

    task automatic model_step(input bit l, r, j, a1, a2, h);
        bit p1, p2;
        p1 = a1 && !m_p1;
        p2 = a2 && !m_p2;
        m_p1 = a1;
        m_p2 = a2;
        if (h) begin
            m_mode = M_HIT; m_t = 0; m_kind = 0; m_bv = 1'b0;
        end else if (m_mode == M_IDLE || m_mode == M_WALK) begin
            m_t = 0; m_kind = 0;
            if (p1)          begin m_mode = M_ATK; m_kind = 1; end
            else if (p2)     begin m_mode = M_ATK; m_kind = 2; end
            else if (j)      m_mode = M_JUMP;
            else if (l != r) begin m_mode = M_WALK; m_dir = r; end
            else             m_mode = M_IDLE;
        end else begin
`ifdef ATTACK_BUFFER_EN
            if (p1)      begin m_bv = 1'b1; m_bk = 1; end
            else if (p2) begin m_bv = 1'b1; m_bk = 2; end
`endif
            if (m_t + 1 >= duration()) begin
                m_t = 0;
                if (m_bv) begin m_mode = M_ATK; m_kind = m_bk; m_bv = 1'b0; end
                else      begin m_mode = M_IDLE; m_kind = 0; end
            end else begin
                m_t = m_t + 1;
            end
        end
    endtask

    function automatic logic [19:0] model_out();
        logic [1:0] at;
        logic [5:0] af, jf;
        at = (m_mode == M_ATK)  ? 2'(m_kind) : 2'd0;
        af = (m_mode == M_ATK)  ? 6'(m_t)    : 6'd0;
        jf = (m_mode == M_JUMP) ? 6'(m_t)    : 6'd0;
        return {m_mode == M_HIT, m_mode == M_ATK, at, af,
                m_mode == M_WALK, m_dir, m_mode == M_JUMP, jf, m_mode >= M_JUMP};
    endfunction

    function automatic logic [19:0] act_vec();
        return {hitstun_active, attack_active, attack_type, attack_frame,
                move_active, move_dir, jump_active, jump_frame, busy};
    endfunction

    task automatic compare(input logic [19:0] e, input string nm);
        logic [19:0] a;
        a = act_vec();
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, a, e, $time);
        end
    endtask

    // One clock of stimulus; the model advances only on SCEN ticks.
    task automatic tick(input bit scen, l, r, j, a1, a2, h, input string nm);
        @(negedge clk);
        SCEN = scen; btn_left = l; btn_right = r; btn_jump = j;
        btn_atk1 = a1; btn_atk2 = a2; hit_in = h;
        if (scen) model_step(l, r, j, a1, a2, h);
        exp_q.push_back('{model_out(), nm});
    endtask

    // Monitor: compare registered outputs just after each rising edge.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            compare(e.v, e.nm);
        end
    end

    initial begin
        reset = 1'b0; SCEN = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
        btn_atk1 = 1'b0; btn_atk2 = 1'b0; hit_in = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        compare(model_out(), "reset_state");
        reset = 1'b1;

        // atk1 press: 12 attack frames then idle.
        tick(1, 0, 0, 0, 1, 0, 0, "atk1_press");
        for (int i = 0; i < 14; i++) tick(1, 0, 0, 0, 1, 0, 0, "atk1_run");
        tick(1, 0, 0, 0, 0, 0, 0, "atk1_release");

        // Simultaneous rise: atk1 wins; atk2 held afterwards is not a press.
        tick(1, 0, 0, 0, 1, 1, 0, "atk_both");
        for (int i = 0; i < 20; i++) tick(1, 0, 0, 0, 0, 1, 0, "atk2_held");
        tick(1, 0, 0, 0, 0, 0, 0, "atk_idle");

        // Jump held; atk2 press while jump_frame shows 10 and again at 20.
        for (int i = 0; i < 70; i++)
            tick(1, 0, 0, 1, 0, (i == 11) || (i == 21), 0, "jump_held");
        for (int i = 0; i < 24; i++) tick(1, 0, 0, 0, 0, 0, 0, "jump_drain");

        // Hit at attack_frame 5, second hit at hitstun count 9.
        tick(1, 0, 0, 0, 1, 0, 0, "hit_atk_press");
        for (int i = 1; i < 45; i++)
            tick(1, 0, 0, 0, 0, 0, (i == 6) || (i == 16), "hitstun");

        // Walk: both held, right only, left only, both again.
        for (int i = 0; i < 3; i++) tick(1, 1, 1, 0, 0, 0, 0, "walk_both");
        for (int i = 0; i < 3; i++) tick(1, 0, 1, 0, 0, 0, 0, "walk_right");
        for (int i = 0; i < 3; i++) tick(1, 1, 0, 0, 0, 0, 0, "walk_left");
        for (int i = 0; i < 3; i++) tick(1, 1, 1, 0, 0, 0, 0, "walk_both2");

        // SCEN low with toggling buttons: nothing moves.
        tick(1, 0, 0, 0, 1, 0, 0, "scen_pre");
        for (int i = 0; i < 50; i++)
            tick(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                 "scen_low");

        // Asynchronous reset in the middle of an attack.
        tick(1, 0, 0, 0, 0, 0, 0, "rst_clear");
        tick(1, 0, 0, 0, 1, 0, 0, "rst_atk");
        for (int i = 0; i < 4; i++) tick(1, 0, 0, 0, 1, 0, 0, "rst_atk_run");
        @(negedge clk);
        SCEN = 1'b0;
        #2 reset = 1'b0;
        #1 model_reset();
        compare(model_out(), "async_reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Randomised traffic.
        for (int i = 0; i < 3000; i++)
            tick($urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 39) == 0, "random");

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
